// File: rtl/mem_req_arbiter.sv
// ============================================================================
// Module   : mem_req_arbiter
// Purpose  : Merges imem (read-only) and dmem (read/write) req/ack ports onto
//            one single-port memory with a fixed read latency. One transaction
//            is in flight at a time. Optional macro MEM_REQ_ARBITER_RR_EN
//            enables round-robin tie breaking (default: dmem has priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_ack_o,
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_latency = 4'(LATENCY);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_grant_d;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_imem_ack;
    logic                  r_dmem_ack;
    logic [DATA_WIDTH-1:0] r_imem_rdata;
    logic [DATA_WIDTH-1:0] r_dmem_rdata;
    logic                  w_grant_d;
    logic                  w_any_req;

`ifdef MEM_REQ_ARBITER_RR_EN
    logic                  r_last_d;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        w_grant_d = dmem_req_i;
        if (imem_req_i && dmem_req_i) begin
            w_grant_d = ~r_last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_last_d <= 1'b1;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    always_comb begin
        w_grant_d = dmem_req_i;
    end
`endif

    assign w_any_req = imem_req_i | dmem_req_i;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_grant_d    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_imem_ack   <= 1'b0;
            r_dmem_ack   <= 1'b0;
            r_imem_rdata <= '0;
            r_dmem_rdata <= '0;
        end else begin
            r_mem_req  <= 1'b0;
            r_imem_ack <= 1'b0;
            r_dmem_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_d   <= w_grant_d;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_grant_d & dmem_we_i;
                        r_mem_addr  <= w_grant_d ? dmem_addr_i : imem_addr_i;
                        r_mem_wdata <= w_grant_d ? dmem_wdata_i : '0;
                        r_cnt       <= c_latency;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Counter reaches zero on the edge where read data is valid.
                    if (r_cnt == 4'd0) begin
                        if (!r_mem_we) begin
                            if (r_grant_d) begin
                                r_dmem_rdata <= mem_rdata_i;
                            end else begin
                                r_imem_rdata <= mem_rdata_i;
                            end
                        end
                        r_dmem_ack <= r_grant_d;
                        r_imem_ack <= ~r_grant_d;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Requests are ignored here so a still-high req is not re-granted.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_rdata_o = r_imem_rdata;
    assign imem_ack_o   = r_imem_ack;
    assign dmem_rdata_o = r_dmem_rdata;
    assign dmem_ack_o   = r_dmem_ack;
    assign mem_req_o    = r_mem_req;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;

endmodule

`default_nettype wire
